serial_lt_cmp: RTL

//  Multi-cycle, chunk-serial magnitude comparator for mixed-width, mixed-signedness operands.

---
 rtl/serial_lt_cmp.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/serial_lt_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : serial_lt_cmp
//  Description : Chunk-serial, MSB-first magnitude comparator for operands of
//                different widths that are either both signed or both
//                unsigned. Operands are taken in over a valid/ready handshake
//                and compared CHUNK bits per cycle. The lt/eq/gt result is
//                returned over a second valid/ready handshake.
//  Ports       : clk, rst          clock (rising edge), async active-high reset
//                in_valid/in_ready operand handshake
//                in_a [AW], in_b [BW], in_signed   operands + signedness
//                out_valid/out_ready result handshake
//                out_lt/out_eq/out_gt one-hot result (0 while out_valid=0)
//                out_lt_ext [RW]   out_lt zero-extended to RW bits
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_lt_cmp #(
  parameter int AW    = 9,
  parameter int BW    = 6,
  parameter int CHUNK = 1,
  parameter int RW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic          in_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_lt,
  output logic          out_eq,
  output logic          out_gt,
  output logic [RW-1:0] out_lt_ext
);

  localparam int W  = (AW > BW) ? AW : BW;
  localparam int N  = (W + CHUNK - 1) / CHUNK;
  localparam int PW = N * CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [W-1:0]  c_msb  = W'(1) << (W - 1);
  localparam logic [CW-1:0] c_last = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_sa;
  logic [PW-1:0]   r_sb;
  logic [CW-1:0]   r_cnt;
  logic            r_dec;
  logic            r_lt;
  logic            r_out_valid;
  logic            r_out_lt;
  logic            r_out_eq;
  logic            r_out_gt;

  logic [W-1:0]    w_ax;
  logic [W-1:0]    w_bx;
  logic [W-1:0]    w_ak;
  logic [W-1:0]    w_bk;
  logic [PW-1:0]   w_pa;
  logic [PW-1:0]   w_pb;
  logic [CHUNK-1:0] w_ta;
  logic [CHUNK-1:0] w_tb;
  logic            w_dec_now;
  logic            w_lt_now;

  // Extend both operands to W bits: sign-fill when signed, zero-fill otherwise.
  for (genvar i = 0; i < W; i++) begin : g_ext
    if (i < AW) begin : g_a_bit
      assign w_ax[i] = in_a[i];
    end else begin : g_a_fill
      assign w_ax[i] = in_signed & in_a[AW-1];
    end
    if (i < BW) begin : g_b_bit
      assign w_bx[i] = in_b[i];
    end else begin : g_b_fill
      assign w_bx[i] = in_signed & in_b[BW-1];
    end
  end

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_ak = w_ax ^ (in_signed ? c_msb : '0);
  assign w_bk = w_bx ^ (in_signed ? c_msb : '0);

  // Zero-pad at the LSB end so the operand is a whole number of chunks.
  assign w_pa = PW'(w_ak) << (PW - W);
  assign w_pb = PW'(w_bk) << (PW - W);

  assign w_ta = r_sa[PW-1 -: CHUNK];
  assign w_tb = r_sb[PW-1 -: CHUNK];

  // Decision including the chunk being examined this cycle; the first
  // differing chunk wins and later chunks are ignored.
  assign w_dec_now = r_dec | (w_ta != w_tb);
  assign w_lt_now  = r_dec ? r_lt : (w_ta < w_tb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_cnt       <= '0;
      r_dec       <= 1'b0;
      r_lt        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_lt    <= 1'b0;
      r_out_eq    <= 1'b0;
      r_out_gt    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sa    <= w_pa;
            r_sb    <= w_pb;
            r_cnt   <= '0;
            r_dec   <= 1'b0;
            r_lt    <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa << CHUNK;
          r_sb  <= r_sb << CHUNK;
          r_cnt <= r_cnt + 1'b1;
          r_dec <= w_dec_now;
          r_lt  <= w_lt_now;
          if (r_cnt == c_last) begin
            r_out_valid <= 1'b1;
            r_out_lt    <= w_dec_now & w_lt_now;
            r_out_gt    <= w_dec_now & ~w_lt_now;
            r_out_eq    <= ~w_dec_now;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_lt    <= 1'b0;
            r_out_eq    <= 1'b0;
            r_out_gt    <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_lt     = r_out_lt;
  assign out_eq     = r_out_eq;
  assign out_gt     = r_out_gt;
  assign out_lt_ext = RW'(r_out_lt);

endmodule
`default_nettype wire
